// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture, sequencer and generator blocks:
// capture state encoding, default counter width and small helpers.
package pwm_pkg;

   localparam int PWM_WIDTH_DEFAULT = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } pwm_state_e;

   function automatic logic all_eq3(input logic a, input logic b, input logic c);
      return (a == b) && (b == c);
   endfunction

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchronizer for the asynchronous PWM input, with an optional
// three-sample glitch filter enabled by macro PWM_CAPTURE_FILTER_EN.
module pwm_sync
   import pwm_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync
);

   logic meta_q;
   logic sync_q;

   // Metastability chain; only sync_q is used downstream.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= i_async;
         sync_q <= meta_q;
      end
   end

`ifdef PWM_CAPTURE_FILTER_EN
   logic hist1_q;
   logic hist2_q;
   logic filt_q;
   logic stable_s;

   // Output follows the synchronized level as soon as three samples agree,
   // which costs exactly two extra cycles per edge.
   assign stable_s = all_eq3(sync_q, hist1_q, hist2_q);
   assign o_sync   = stable_s ? sync_q : filt_q;

   // Sample history and the held filtered level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hist1_q <= 1'b0;
         hist2_q <= 1'b0;
         filt_q  <= 1'b0;
      end else begin
         hist1_q <= sync_q;
         hist2_q <= hist1_q;
         filt_q  <= o_sync;
      end
   end
`else
   assign o_sync = sync_q;
`endif

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input and flags a
// timeout with the stuck level. Optional glitch filter: PWM_CAPTURE_FILTER_EN.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pwm,
   output logic [WIDTH-1:0] o_period,
   output logic [WIDTH-1:0] o_high,
   output logic             o_valid,
   output logic             o_timeout,
   output logic             o_level
);

   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

   logic             sync_s;
   logic             prev_q;
   logic             rise_q;
   logic             fall_q;
   pwm_state_e       state_q,   state_d;
   logic [WIDTH-1:0] cnt_q,     cnt_d;
   logic [WIDTH-1:0] shadow_q,  shadow_d;
   logic [WIDTH-1:0] period_q,  period_d;
   logic [WIDTH-1:0] high_q,    high_d;
   logic             level_q,   level_d;
   logic             valid_q,   valid_d;
   logic             timeout_q, timeout_d;
   logic [WIDTH-1:0] cnt_inc_s;

   pwm_sync u_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_async (i_pwm),
      .o_sync  (sync_s)
   );

   // Registered edge detector; prev_q doubles as the level reported on timeout.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         prev_q <= sync_s;
         rise_q <= sync_s & ~prev_q;
         fall_q <= ~sync_s & prev_q;
      end
   end

   // Saturating so a fall landing on the last count cannot wrap the period.
   assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

   // Measurement FSM: an edge always wins over the timeout on the same cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      period_d  = period_q;
      high_d    = high_q;
      level_d   = level_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise_q) begin
               cnt_d   = CNT_ONE;
               state_d = ST_HIGH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HIGH: begin
            if (fall_q) begin
               shadow_d = cnt_q;
               cnt_d    = cnt_inc_s;
               state_d  = ST_LOW;
            end else if (cnt_q == CNT_MAX) begin
               timeout_d = 1'b1;
               level_d   = prev_q;
               cnt_d     = CNT_ZERO;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         ST_LOW: begin
            if (rise_q) begin
               period_d = cnt_q;
               high_d   = shadow_q;
               valid_d  = 1'b1;
               cnt_d    = CNT_ONE;
               state_d  = ST_HIGH;
            end else if (cnt_q == CNT_MAX) begin
               timeout_d = 1'b1;
               level_d   = prev_q;
               cnt_d     = CNT_ZERO;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         default: begin
            cnt_d   = CNT_ZERO;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= CNT_ZERO;
         shadow_q  <= CNT_ZERO;
         period_q  <= CNT_ZERO;
         high_q    <= CNT_ZERO;
         level_q   <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         period_q  <= period_d;
         high_q    <= high_d;
         level_q   <= level_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_period  = period_q;
   assign o_high    = high_q;
   assign o_valid   = valid_q;
   assign o_timeout = timeout_q;
   assign o_level   = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a WIDTH=9 and a WIDTH=4 instance, each checked every
// cycle against a timestamp-based model of the input waveform.
module tb_pwm_capture;

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 3;
`endif

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic pwm0 = 1'b0;
   logic pwm1 = 1'b0;

   logic [8:0] p9, h9;
   logic       v9, t9, l9;
   logic [3:0] p4, h4;
   logic       v4, t4, l4;

   pwm_capture #(.WIDTH(9)) u_dut9 (
      .i_clk(clk), .i_rst(rst), .i_pwm(pwm0),
      .o_period(p9), .o_high(h9), .o_valid(v9), .o_timeout(t9), .o_level(l9)
   );

   pwm_capture #(.WIDTH(4)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_pwm(pwm1),
      .o_period(p4), .o_high(h4), .o_valid(v4), .o_timeout(t4), .o_level(l4)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   logic smp0, smp1, smp_rst;

   // What the DUTs saw at each rising edge.
   always @(posedge clk) begin
      smp0    <= pwm0;
      smp1    <= pwm1;
      smp_rst <= rst;
      cyc     <= cyc + 1;
   end

   // Model: raw sample history, synchronized/filtered level history, and the
   // measurement expressed as timestamps of accepted edges.
   logic hs [2][4];
   logic gs [2][4];
   bit   act [2];
   bit   hi  [2];
   int   rise_t [2];
   int   shadow [2];
   int   e_per  [2];
   int   e_hi   [2];
   int   e_lvl  [2];
   int   e_val  [2];
   int   e_to   [2];
   int   maxv   [2] = '{511, 15};
   int   m_nv [2] = '{0, 0};
   int   m_nt [2] = '{0, 0};
   int   m_lp [2] = '{0, 0};
   int   m_lh [2] = '{0, 0};
   int   m_fv [2] = '{-1, -1};
   int   m_tc [2] = '{0, 0};
   int   m_tl [2] = '{0, 0};

   task automatic check(input string name, input int act_v, input int exp_v);
      n_cmp++;
      if (act_v != exp_v) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act_v, exp_v);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_step(input int c, input logic p, input logic r);
      logic gnew, rise, fall;
      int   el;
      e_val[c] = 0;
      e_to[c]  = 0;
      if (r) begin
         for (int i = 0; i < 4; i++) begin
            hs[c][i] = 1'b0;
            gs[c][i] = 1'b0;
         end
         act[c] = 0; hi[c] = 0; shadow[c] = 0;
         e_per[c] = 0; e_hi[c] = 0; e_lvl[c] = 0;
      end else begin
         for (int i = 3; i > 0; i--) hs[c][i] = hs[c][i-1];
         hs[c][0] = p;
`ifdef PWM_CAPTURE_FILTER_EN
         gnew = (hs[c][1] == hs[c][2] && hs[c][2] == hs[c][3]) ? hs[c][1] : gs[c][0];
`else
         gnew = hs[c][1];
`endif
         for (int i = 3; i > 0; i--) gs[c][i] = gs[c][i-1];
         gs[c][0] = gnew;
         rise = gs[c][2] & ~gs[c][3];
         fall = ~gs[c][2] & gs[c][3];
         el   = cyc - rise_t[c];
         if (!act[c]) begin
            if (rise) begin act[c] = 1; hi[c] = 1; rise_t[c] = cyc; end
         end else if (hi[c]) begin
            if (fall) begin
               shadow[c] = imin(el, maxv[c]); hi[c] = 0;
            end else if (el >= maxv[c]) begin
               e_to[c] = 1; e_lvl[c] = int'(gs[c][2]); act[c] = 0;
            end
         end else begin
            if (rise) begin
               e_per[c] = imin(el, maxv[c]); e_hi[c] = shadow[c];
               e_val[c] = 1; rise_t[c] = cyc; hi[c] = 1;
            end else if (el >= maxv[c]) begin
               e_to[c] = 1; e_lvl[c] = int'(gs[c][2]); act[c] = 0;
            end
         end
         if (e_val[c] == 1) begin
            m_nv[c]++; m_lp[c] = e_per[c]; m_lh[c] = e_hi[c];
            if (m_fv[c] < 0) m_fv[c] = cyc;
         end
         if (e_to[c] == 1) begin
            m_nt[c]++; m_tc[c] = cyc; m_tl[c] = e_lvl[c];
         end
      end
   endtask

   task automatic check_cycle(input int c, input int per, input int hgh,
                              input logic val, input logic to, input logic lvl);
      check($sformatf("ch%0d valid", c),   int'(val), e_val[c]);
      check($sformatf("ch%0d timeout", c), int'(to),  e_to[c]);
      check($sformatf("ch%0d period", c),  per,       e_per[c]);
      check($sformatf("ch%0d high", c),    hgh,       e_hi[c]);
      check($sformatf("ch%0d level", c),   int'(lvl), e_lvl[c]);
      check($sformatf("ch%0d valid_and_timeout", c), int'(val & to), 0);
   endtask

   // Single compare process, away from the rising edge.
   always @(negedge clk) begin
      if (cyc > 0) begin
         model_step(0, smp0, smp_rst);
         model_step(1, smp1, smp_rst);
         check_cycle(0, int'(p9), int'(h9), v9, t9, l9);
         check_cycle(1, int'(p4), int'(h4), v4, t4, l4);
      end
   end

   task automatic drive(input int c, input logic v, input int n);
      if (c == 0) pwm0 = v;
      else        pwm1 = v;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   int s2, sr, bv, bt;

   initial begin
      @(posedge clk); #2;
      repeat (2) begin @(posedge clk); #2; end
      rst = 1'b0;
      check("reset period9", int'(p9), 0);
      check("reset valid9", int'(v9), 0);

      // 3 high / 5 low repeated on the wide channel.
      for (int i = 0; i < 6; i++) begin
         if (i == 1) s2 = cyc + 1;
         drive(0, 1'b1, 3);
         drive(0, 1'b0, 5);
      end
      drive(0, 1'b0, 6);
      check("p1 valid count", m_nv[0], 5);
      check("p1 period", m_lp[0], 8);
      check("p1 high", m_lh[0], 3);
      check("p1 latency", m_fv[0] - s2, LAT);
      check("p1 dut period", int'(p9), 8);

      // Narrow channel: one period, then stuck low.
      bv = m_nv[1]; bt = m_nt[1];
      drive(1, 1'b1, 4); drive(1, 1'b0, 6);
      sr = cyc + 1;
      drive(1, 1'b1, 4); drive(1, 1'b0, 30);
      check("p2 valid count", m_nv[1] - bv, 1);
      check("p2 period", m_lp[1], 10);
      check("p2 high", m_lh[1], 4);
      check("p2 timeout count", m_nt[1] - bt, 1);
      check("p2 timeout level", m_tl[1], 0);
      check("p2 timeout cycle", m_tc[1] - sr, LAT + 15);
      bv = m_nv[1];
      drive(1, 1'b1, 3); drive(1, 1'b0, 3); drive(1, 1'b1, 3); drive(1, 1'b0, 20);
      check("p2 rearm valid count", m_nv[1] - bv, 1);
      check("p2 rearm period", m_lp[1], 6);

      // Period of exactly 15 on the narrow channel: edge beats timeout.
      bv = m_nv[1]; bt = m_nt[1];
      for (int i = 0; i < 3; i++) begin
         drive(1, 1'b1, 5); drive(1, 1'b0, 10);
      end
      drive(1, 1'b1, 5); drive(1, 1'b0, 4);
      check("p3 valid count", m_nv[1] - bv, 3);
      check("p3 period", m_lp[1], 15);
      check("p3 high", m_lh[1], 5);
      check("p3 no timeout", m_nt[1] - bt, 0);
      check("p3 dut period", int'(p4), 15);
      drive(1, 1'b0, 20);

      // Stuck high on the narrow channel.
      bt = m_nt[1];
      drive(1, 1'b1, 25);
      check("p4 timeout count", m_nt[1] - bt, 1);
      check("p4 timeout level", m_tl[1], 1);
      drive(1, 1'b0, 5);

      // Reset in the middle of a high phase.
      drive(0, 1'b1, 3); drive(0, 1'b0, 5); drive(0, 1'b1, 2);
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      check("p5 period after reset", int'(p9), 0);
      check("p5 high after reset", int'(h9), 0);
      bv = m_nv[0];
      drive(0, 1'b1, 3); drive(0, 1'b0, 5); drive(0, 1'b1, 3); drive(0, 1'b0, 6);
      check("p5 valid after two rises", m_nv[0] - bv, 1);

      // One-cycle glitch in every low phase.
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, 4); drive(0, 1'b0, 3); drive(0, 1'b1, 1); drive(0, 1'b0, 4);
      end
      drive(0, 1'b1, 4); drive(0, 1'b0, 8);
`ifdef PWM_CAPTURE_FILTER_EN
      check("p6 period", m_lp[0], 12);
      check("p6 high", m_lh[0], 4);
`else
      check("p6 period", m_lp[0], 5);
      check("p6 high", m_lh[0], 1);
`endif

      // Randomized waveforms on both channels at once.
      fork
         begin
            int hl, ll;
            repeat (50) begin
               hl = int'($urandom_range(40, 1));
               ll = ($urandom_range(9, 0) == 0) ? 600 : int'($urandom_range(40, 1));
               drive(0, 1'b1, hl);
               drive(0, 1'b0, ll);
            end
         end
         begin
            int hl, ll;
            repeat (150) begin
               hl = int'($urandom_range(16, 1));
               ll = int'($urandom_range(16, 1));
               drive(1, 1'b1, hl);
               drive(1, 1'b0, ll);
            end
         end
      join
      drive(0, 1'b0, 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 9, giving the bit width of the period and high-time counters and outputs.
REQ-002 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_pwm  input  1  PWM signal, asynchronous to i_clk.
REQ-005 SHALL have port o_period  output  WIDTH  clock cycles from one accepted rising edge to the next.
REQ-006 SHALL have port o_high  output  WIDTH  clock cycles from an accepted rising edge to the following accepted falling edge.
REQ-007 SHALL have port o_valid  output  1  one-cycle strobe; o_period and o_high are updated on the same cycle.
REQ-008 SHALL have port o_timeout  output  1  one-cycle strobe: no edge seen for 2^WIDTH-1 cycles.
REQ-009 SHALL have port o_level  output  1  synchronized level captured when o_timeout fires: 0 means 0 % duty, 1 means 100 % duty.

Function
REQ-010 SHALL pass i_pwm through a 2-flop synchronizer, then edge-detect it against a registered copy; "accepted edge" means an edge at the edge-detector output.
REQ-011 SHALL implement states IDLE, HIGH and LOW.
REQ-012 SHALL leave IDLE only on an accepted rise, going to HIGH, with the counter loaded to 1 and no output.
REQ-013 SHALL, in HIGH, increment the counter each cycle; an accepted fall latches the counter into a shadow high register and moves to LOW.
REQ-014 SHALL, in LOW, increment the counter each cycle; an accepted rise drives o_period = counter, o_high = shadow, pulses o_valid, reloads the counter to 1 and moves to HIGH.
REQ-015 SHALL measure period as rise-inclusive to next-rise-exclusive; e.g. i_pwm high 3 cycles and low 5 cycles gives o_period=8, o_high=3.
REQ-016 SHALL, when the counter equals 2^WIDTH-1 in HIGH or LOW with no accepted edge that cycle, pulse o_timeout, set o_level to the synchronized level, leave o_period/o_high unchanged and go to IDLE.
REQ-017 SHALL let the edge win when an accepted edge coincides with counter = 2^WIDTH-1: normal transition, no timeout, and o_period may equal 2^WIDTH-1.
REQ-018 SHALL never assert o_timeout while in IDLE; a constant input after reset produces no strobes.
REQ-019 SHALL assert o_valid exactly 3 i_clk cycles after the first i_clk edge that samples i_pwm high, with i_pwm driven synchronously, filter disabled.
REQ-020 SHALL never assert o_valid and o_timeout in the same cycle.

Reset
REQ-021 SHALL, while i_rst is high, force the state to IDLE, the counter, shadow, o_period, o_high and o_level to 0, o_valid and o_timeout to 0, and both synchronizer flops to 0.
REQ-022 SHALL, when i_rst is asserted mid-measurement, discard the partial measurement; the first o_valid after reset requires two full accepted rises.

Configuration
REQ-023 SHALL provide macro PWM_CAPTURE_FILTER_EN.
REQ-024 SHALL, when PWM_CAPTURE_FILTER_EN is defined, insert a glitch filter after the synchronizer: the filtered level changes only after 3 consecutive equal samples, adding 2 cycles of latency to every edge and to REQ-019.
REQ-025 SHALL, when PWM_CAPTURE_FILTER_EN is defined, suppress pulses shorter than 3 cycles entirely.
REQ-026 SHALL, when PWM_CAPTURE_FILTER_EN is undefined, use the 2-flop synchronizer only; measured values are identical in both builds for clean input.

Structure
REQ-027 SHALL place the state encoding (IDLE/HIGH/LOW) and the default WIDTH constant in shared package pwm_pkg, also usable by pwm_sequencer and pwm.
REQ-028 SHALL implement the synchronizer plus optional filter as sub-module pwm_sync (in i_clk, i_rst, i_async; out o_sync).

Verification
REQ-029 SHALL cover: reset, then i_pwm high 3 / low 5 repeated -> first o_valid after the second rise with o_period=8, o_high=3; same values every 8 cycles thereafter.
REQ-030 SHALL cover: duty sweep driven by pwm_sequencer + pwm looped back -> every o_period/o_high equals the programmed top+1 / compare values.
REQ-031 SHALL cover: WIDTH=4, i_pwm held 0 after one full period -> o_timeout after 15 cycles in LOW with o_level=0; no o_valid until two further rises.
REQ-032 SHALL cover: WIDTH=4, period exactly 15 -> o_valid with o_period=15 and no o_timeout (REQ-017).
REQ-033 SHALL cover: i_rst pulsed during HIGH -> all outputs 0 the next cycle; the next o_valid occurs only after two accepted rises.
REQ-034 SHALL cover: PWM_CAPTURE_FILTER_EN defined, 1-cycle glitches injected into low phase -> o_period/o_high unchanged and latency +2 versus the unfiltered build.
